// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and the mod-36000 fold used by the DDS phase generator.
package dds_pkg;

  localparam int unsigned ANGLE_FULL = 36000;
  localparam int unsigned ANGLE_HALF = 18000;
  localparam int unsigned CORDIC_LAT = 10;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  // Valid only for x < 2*ANGLE_FULL: a single conditional subtract.
  function automatic logic [15:0] mod_full(input logic [16:0] x);
    logic [16:0] r;
    r = (x >= 17'(ANGLE_FULL)) ? x - 17'(ANGLE_FULL) : x;
    return r[15:0];
  endfunction

endpackage

// File: rtl/dds_mod_add.sv
// Combinational a + b + cin modulo 36000; both operands must already be below 36000.
module dds_mod_add
  import dds_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [16:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    sum = mod_full(raw);
  end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator: centi-degree angle held for a programmable sample period, with a
// CORDIC-valid strobe. Define DDS_PHASE_SWEEP_EN to add a cfg_step input for sawtooth chirps.
module dds_phase_gen #(
  parameter int unsigned FRAC_W     = 16,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned CORDIC_LAT = dds_pkg::CORDIC_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [16+FRAC_W-1:0] cfg_ftw,
  input  logic [15:0]         cfg_offset,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef DDS_PHASE_SWEEP_EN
  input  logic [16+FRAC_W-1:0] cfg_step,
`endif
  output logic [15:0]         angle,
  output logic                cordic_start,
  output logic                sample_valid,
  output logic                cfg_err
);
  import dds_pkg::*;

  localparam int unsigned FTW_W = 16 + FRAC_W;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(CORDIC_LAT + 1);
  localparam logic [FTW_W-1:0] FTW_MAX = {16'(ANGLE_HALF - 1), {FRAC_W{1'b1}}};

  state_t state, state_next;

  logic [DIV_W-1:0]  cnt, div, sh_div, acc_div_c;
  logic [15:0]       acc_int, acc_int_next, offset, sh_off, off_eff, angle_next, acc_off_c;
  logic [FRAC_W-1:0] acc_frac, acc_frac_next;
  logic              frac_carry;
  logic [FTW_W-1:0]  ftw, sh_ftw, ftw_eff, ftw_upd, acc_ftw_c;
  logic              pending, period_end, update, apply, clamp;
`ifdef DDS_PHASE_SWEEP_EN
  localparam logic [FTW_W:0] SWEEP_LIM = {1'b0, 16'(ANGLE_HALF), {FRAC_W{1'b0}}};
  logic [FTW_W-1:0] step, sh_step, step_eff, base, base_eff;
  logic [FTW_W:0]   sweep_sum;
`endif

  dds_mod_add u_acc_add (
    .a   (acc_int),
    .b   (ftw_eff[FTW_W-1:FRAC_W]),
    .cin (frac_carry),
    .sum (acc_int_next)
  );

  dds_mod_add u_off_add (
    .a   (acc_int_next),
    .b   (off_eff),
    .cin (1'b0),
    .sum (angle_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (en) state_next = PRIME;
      PRIME:   state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cordic_start = (state != IDLE);
    sample_valid = (state == RUN) && (cnt == DIV_W'(CORDIC_LAT));
    cfg_ready    = !pending;
  end

  // A pending shadow is consumed by the same edge that uses it, so the update sees it directly.
  always_comb begin
    ftw_eff    = pending ? sh_ftw : ftw;
    off_eff    = pending ? sh_off : offset;
    {frac_carry, acc_frac_next} = {1'b0, acc_frac} + {1'b0, ftw_eff[FRAC_W-1:0]};
    period_end = (cnt == div - DIV_W'(1));
    update     = (state == RUN) && en && period_end;
    apply      = pending && ((state == PRIME) || update);
`ifdef DDS_PHASE_SWEEP_EN
    step_eff   = pending ? sh_step : step;
    base_eff   = pending ? sh_ftw : base;
    sweep_sum  = {1'b0, ftw_eff} + {1'b0, step_eff};
    ftw_upd    = (sweep_sum >= SWEEP_LIM) ? base_eff : sweep_sum[FTW_W-1:0];
`else
    ftw_upd    = ftw_eff;
`endif
    acc_ftw_c  = (cfg_ftw[FTW_W-1:FRAC_W] >= 16'(ANGLE_HALF)) ? FTW_MAX : cfg_ftw;
    acc_off_c  = (cfg_offset >= 16'(ANGLE_FULL)) ? cfg_offset - 16'(ANGLE_FULL) : cfg_offset;
    acc_div_c  = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
    clamp      = (cfg_ftw[FTW_W-1:FRAC_W] >= 16'(ANGLE_HALF)) ||
                 (cfg_offset >= 16'(ANGLE_FULL)) || (cfg_div < DIV_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_int  <= '0;
      acc_frac <= '0;
      cnt      <= '0;
      angle    <= '0;
      ftw      <= '0;
      offset   <= '0;
      div      <= DIV_MIN;
      pending  <= 1'b0;
      sh_ftw   <= '0;
      sh_off   <= '0;
      sh_div   <= DIV_MIN;
      cfg_err  <= 1'b0;
`ifdef DDS_PHASE_SWEEP_EN
      step     <= '0;
      sh_step  <= '0;
      base     <= '0;
`endif
    end else begin
      if (state == PRIME) begin
        acc_int  <= '0;
        acc_frac <= '0;
        cnt      <= '0;
        angle    <= off_eff;
      end else if (state == RUN && en) begin
        if (period_end) begin
          acc_int  <= acc_int_next;
          acc_frac <= acc_frac_next;
          angle    <= angle_next;
          cnt      <= '0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end

      if (update)     ftw <= ftw_upd;
      else if (apply) ftw <= sh_ftw;

      if (apply) begin
        offset <= sh_off;
        div    <= sh_div;
`ifdef DDS_PHASE_SWEEP_EN
        step   <= sh_step;
        base   <= sh_ftw;
`endif
      end

      if (pending) begin
        if (apply) pending <= 1'b0;
      end else if (cfg_valid) begin
        sh_ftw  <= acc_ftw_c;
        sh_off  <= acc_off_c;
        sh_div  <= acc_div_c;
`ifdef DDS_PHASE_SWEEP_EN
        sh_step <= cfg_step;
`endif
        pending <= 1'b1;
        if (clamp) cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: directed literal scenarios plus randomized traffic
// checked every cycle against a phase-arithmetic model (sweep scenario under DDS_PHASE_SWEEP_EN).
`timescale 1ns/1ps
module tb_dds_phase_gen;
  localparam int FRAC_W = 16;
  localparam int DIV_W  = 8;
  localparam longint FULL = 64'd36000 << FRAC_W;
  localparam longint HALF = 64'd18000 << FRAC_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_ftw = '0;
  logic [15:0] cfg_offset = '0;
  logic [7:0]  cfg_div = 8'd12;
`ifdef DDS_PHASE_SWEEP_EN
  logic [31:0] cfg_step = '0;
`endif
  logic [15:0] angle;
  logic        cordic_start, sample_valid, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_phase_gen #(.FRAC_W(FRAC_W), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ftw      (cfg_ftw),
    .cfg_offset   (cfg_offset),
    .cfg_div      (cfg_div),
`ifdef DDS_PHASE_SWEEP_EN
    .cfg_step     (cfg_step),
`endif
    .angle        (angle),
    .cordic_start (cordic_start),
    .sample_valid (sample_valid),
    .cfg_err      (cfg_err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase kept as one integer in 2^-16 centi-degree units.
  int     m_mode;  // 0 stopped, 1 priming, 2 running
  int     m_pos, m_angle;
  longint m_phase;
  bit     m_pending, m_err;
  longint a_ftw, a_step, a_base, s_ftw, s_step;
  int     a_off, a_div, s_off, s_div;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_angle = 0; m_phase = 0;
    m_pending = 0; m_err = 0;
    a_ftw = 0; a_step = 0; a_base = 0; a_off = 0; a_div = 11;
    s_ftw = 0; s_step = 0; s_off = 0; s_div = 11;
  endtask

  task automatic load_active();
    a_ftw = s_ftw; a_base = s_ftw; a_step = s_step; a_off = s_off; a_div = s_div;
    m_pending = 0;
  endtask

  task automatic model_step();
    bit take;
    longint nf;
    take = cfg_valid && !m_pending;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (m_pending) load_active();
        m_phase = 0; m_pos = 0; m_angle = a_off; m_mode = 2;
      end
      default: begin
        if (!en) m_mode = 0;
        else if (m_pos == a_div - 1) begin
          if (m_pending) load_active();
          m_phase = (m_phase + a_ftw) % FULL;
          m_angle = int'(((m_phase >> FRAC_W) + a_off) % 36000);
          nf = a_ftw + a_step;
`ifdef DDS_PHASE_SWEEP_EN
          a_ftw = (nf >= HALF) ? a_base : nf;
`endif
          m_pos = 0;
        end else m_pos++;
      end
    endcase
    if (take) begin
      s_ftw = longint'(cfg_ftw);
      if (s_ftw >= HALF) begin s_ftw = HALF - 1; m_err = 1; end
      s_off = int'(cfg_offset);
      if (s_off >= 36000) begin s_off -= 36000; m_err = 1; end
      s_div = int'(cfg_div);
      if (s_div < 11) begin s_div = 11; m_err = 1; end
`ifdef DDS_PHASE_SWEEP_EN
      s_step = longint'(cfg_step);
`else
      s_step = 0;
`endif
      m_pending = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    chk("m_angle", longint'(angle), longint'(m_angle));
    chk("m_cordic_start", longint'(cordic_start), longint'(m_mode != 0));
    chk("m_sample_valid", longint'(sample_valid), longint'(m_mode == 2 && m_pos == 10));
    chk("m_cfg_ready", longint'(cfg_ready), longint'(!m_pending));
    chk("m_cfg_err", longint'(cfg_err), longint'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] f, input int o, input int d, input logic [31:0] s);
    cfg_ftw = f; cfg_offset = 16'(o); cfg_div = 8'(d);
`ifdef DDS_PHASE_SWEEP_EN
    cfg_step = s;
`else
    if (s != 0) $display("note: step ignored without sweep");
`endif
    cfg_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (cfg_ready) begin
        tick(1);
        cfg_valid = 1'b0;
        return;
      end
      tick(1);
    end
    chk("offer_timeout", 1, 0);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_change(output int cycles);
    logic [15:0] old;
    old = angle;
    cycles = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      cycles++;
      if (angle != old) return;
    end
    chk("angle_change_timeout", 1, 0);
  endtask

  int c, hold, sv_seen;
  int t2_exp[4] = '{3000, 12000, 21000, 30000};
  int t3_exp[3] = '{17999, 35999, 17999};
  int t6_exp[4] = '{17000, 34500, 15500, 33000};
  logic [15:0] old_angle;
  logic [31:0] rf;
  bit will_take;

  initial begin
    tick(2);
    chk("rst_angle", longint'(angle), 0);
    chk("rst_cordic_start", longint'(cordic_start), 0);
    chk("rst_sample_valid", longint'(sample_valid), 0);
    chk("rst_cfg_ready", longint'(cfg_ready), 1);
    chk("rst_cfg_err", longint'(cfg_err), 0);
    rst_n = 1'b1;
    tick(1);

    // 1: fixed tone 1000.0, period 12
    offer(32'd1000 << 16, 0, 12, 0);
    chk("t1_pending_ready", longint'(cfg_ready), 0);
    en = 1'b1;
    tick(2);
    chk("t1_prime_angle", longint'(angle), 0);
    chk("t1_cordic_start", longint'(cordic_start), 1);
    tick(10);
    chk("t1_sv_at_lat", longint'(sample_valid), 1);
    tick(1);
    chk("t1_sv_single", longint'(sample_valid), 0);
    for (int k = 1; k <= 36; k++) begin
      wait_change(c);
      chk("t1_angle", longint'(angle), longint'((k * 1000) % 36000));
      if (k > 1) chk("t1_period", c, 12);
    end

    // 2: offset wrap
    en = 1'b0;
    tick(2);
    offer(32'd9000 << 16, 30000, 12, 0);
    en = 1'b1;
    tick(2);
    chk("t2_prime_angle", longint'(angle), 30000);
    for (int k = 0; k < 4; k++) begin
      wait_change(c);
      chk("t2_angle", longint'(angle), t2_exp[k]);
    end

    // 3: clamps and sticky error
    en = 1'b0;
    tick(2);
    offer(32'd20000 << 16, 0, 3, 0);
    chk("t3_err_set", longint'(cfg_err), 1);
    en = 1'b1;
    tick(2);
    chk("t3_prime_angle", longint'(angle), 0);
    for (int k = 0; k < 3; k++) begin
      wait_change(c);
      chk("t3_angle", longint'(angle), t3_exp[k]);
      chk("t3_period", c, 11);
    end
    offer(32'd1000 << 16, 0, 12, 0);
    wait_change(c);
    wait_change(c);
    chk("t3_err_sticky", longint'(cfg_err), 1);

    // 4: mid-period config, stall, apply at period end
    wait_change(c);
    tick(5);
    cfg_ftw = 32'd2000 << 16; cfg_offset = '0; cfg_div = 8'd20; cfg_valid = 1'b1;
    tick(1);
    chk("t4_ready_fall", longint'(cfg_ready), 0);
    cfg_ftw = 32'd3000 << 16; cfg_div = 8'd15;
    old_angle = angle;
    tick(5);
    chk("t4_stall", longint'(cfg_ready), 0);
    chk("t4_hold_before_update", longint'(angle), longint'(old_angle));
    tick(1);
    chk("t4_new_ftw", longint'((int'(angle) - int'(old_angle) + 36000) % 36000), 2000);
    chk("t4_ready_rise", longint'(cfg_ready), 1);
    tick(1);
    cfg_valid = 1'b0;
    chk("t4_second_accept", longint'(cfg_ready), 0);
    old_angle = angle;
    wait_change(c);
    chk("t4_period_div20", c, 19);
    chk("t4_second_ftw", longint'((int'(angle) - int'(old_angle) + 36000) % 36000), 3000);
    old_angle = angle;
    wait_change(c);
    chk("t4_period_div15", c, 15);

    // 5: en drop mid-period, re-prime, async reset
    wait_change(c);
    tick(4);
    en = 1'b0;
    hold = m_angle;
    tick(1);
    chk("t5_cordic_off", longint'(cordic_start), 0);
    sv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (sample_valid) sv_seen++;
    end
    chk("t5_no_sv", sv_seen, 0);
    chk("t5_angle_held", longint'(angle), longint'(hold));
    en = 1'b1;
    tick(2);
    chk("t5_prime_offset", longint'(angle), 0);
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_angle", longint'(angle), 0);
    chk("t5_rst_cordic_start", longint'(cordic_start), 0);
    chk("t5_rst_sample_valid", longint'(sample_valid), 0);
    chk("t5_rst_cfg_ready", longint'(cfg_ready), 1);
    chk("t5_rst_cfg_err", longint'(cfg_err), 0);
    en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

`ifdef DDS_PHASE_SWEEP_EN
    // 6: sawtooth chirp 17000 -> 17500 -> reload
    offer(32'd17000 << 16, 0, 12, 32'd500 << 16);
    en = 1'b1;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      wait_change(c);
      chk("t6_angle", longint'(angle), t6_exp[k]);
    end
    en = 1'b0;
    tick(2);
`endif

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        cfg_valid = 1'b0;
      end
      if (!cfg_valid && $urandom_range(0, 29) == 0) begin
        rf = $urandom;
        if ($urandom_range(0, 3) != 0) rf[31:16] = 16'($urandom_range(0, 17999));
        cfg_ftw = rf;
        cfg_offset = 16'($urandom_range(0, 40000));
        cfg_div = 8'($urandom_range(1, 30));
`ifdef DDS_PHASE_SWEEP_EN
        cfg_step = ($urandom_range(0, 3000) << 16) | ($urandom & 32'hFFFF);
`endif
        cfg_valid = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) en = ~en;
      if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      will_take = cfg_valid && cfg_ready;
      tick(1);
      if (will_take) cfg_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
